dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port `dmem`. It shares the data memory between port 0 (core load/store unit) and port 1 (debug/DMA loader). It accepts one request at a time over a valid/ready handshake and drives `dmem`'s `en`/`w_en`/`addr`/`din` for exactly one cycle. It then waits the memory read latency and returns a one-cycle response, carrying read data or an alignment error, to the granted port.

## Interface
- `MEM_LAT`, default 1: cycles from the read-issue cycle until `mem_dout` is valid; legal range 1–7.
- `AW`, default 32: address width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_valid`, `p1_valid`  in  1  request present.
- `p0_ready`, `p1_ready`  out  1  request accepted this cycle.
- `p0_we`, `p1_we`  in  4  byte write enables; 4'b0000 means read.
- `p0_addr`, `p1_addr`  in  AW  byte address.
- `p0_wdata`, `p1_wdata`  in  32  write data, byte lanes already aligned.
- `p0_resp_valid`, `p1_resp_valid`  out  1  one-cycle response strobe.
- `p0_resp_err`, `p1_resp_err`  out  1  misaligned access, qualified by resp_valid.
- `p0_rdata`, `p1_rdata`  out  32  read data, held until the next response to that port.
- `mem_en`  out  2  to `dmem.en`: 2'b10 write, 2'b01 read, 2'b00 idle.
- `mem_w_en`  out  4  to `dmem.w_en`.
- `mem_addr`  out  AW  to `dmem.addr`.
- `mem_din`  out  32  to `dmem.din`.
- `mem_dout`  in  32  from `dmem.dout`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any valid is high, pick a winner and assert its ready combinationally in the same cycle.
  - Latch we/addr/wdata and the grant id, then go to ISSUE.
  - The losing port's ready stays low; it must hold its request.
- Alignment check at accept: error if `we`=4'b1111 and addr[1:0]≠0, or if `we` is 4'b0011/4'b1100 with addr[0]≠0. Reads (we=0) with addr[1:0]≠0 are also errors.
  - On error, skip ISSUE/WAIT and go straight to RESP with err=1.
  - `mem_en` stays 2'b00 for the whole erroneous transaction.
- ISSUE, one cycle:
  - `mem_en`=2'b10 if we≠0, else 2'b01.
  - `mem_w_en`=we; `mem_addr`={addr[AW-1:2],2'b00}; `mem_din`=wdata.
  - Write: next state RESP. Read: next state WAIT, counter loaded with MEM_LAT-1.
- WAIT:
  - `mem_en`=2'b00.
  - When the counter reaches 0, capture `mem_dout` into the granted port's rdata register and go to RESP. Otherwise decrement.
- RESP, one cycle:
  - Granted port's resp_valid=1 and resp_err per the check. Writes leave rdata unchanged.
  - Return to IDLE; a new accept is possible in the following cycle.
- Outside ISSUE, `mem_en`=2'b00, `mem_w_en`=4'b0000, and `mem_addr`/`mem_din` hold their last values.
- Only one transaction is outstanding at a time; no pipelining.

## Timing
- Accept at cycle T.
  - Write: ISSUE at T+1, resp_valid at T+2.
  - Read: ISSUE at T+1, data sampled at T+1+MEM_LAT, resp_valid at T+2+MEM_LAT.
  - Error: resp_valid at T+1.
- Write throughput is one transaction per 3 cycles. Read throughput is one per 3+MEM_LAT cycles.
- Reset values:
  - State IDLE; readys 0; resp_valids 0; errs 0.
  - rdata 32'h0; `mem_en` 2'b00; `mem_w_en` 0; `mem_addr` 0; `mem_din` 0.
  - Grant pointer points at port 1, so port 0 wins first.
- Reset asserted mid-transaction: everything returns to reset values immediately. No response is issued, and the aborted request is not retried.
- A port whose valid drops before ready sees no side effects.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous valids, the port not granted last wins.
  - The pointer updates only on accept.
- Undefined: fixed priority, port 0 always wins and port 1 can starve. The pointer logic is not built.

## Test plan
- Single write: p0 writes 32'h20221118 to 32'h00100000 with we=4'b1111.
  - Expect `mem_en`=2'b10, `mem_w_en`=4'b1111, `mem_addr`=32'h00100000 for exactly one cycle.
  - Expect p0_resp_valid at T+2 with err=0.
- Read-back: p1 reads 32'h00100000 with MEM_LAT=1 and the memory model returning 32'h20221118.
  - Expect `mem_en`=2'b01 for one cycle.
  - Expect p1_resp_valid at T+3 and p1_rdata=32'h20221118; p0_rdata unchanged.
- Contention: both ports hold valid for 4 transactions to 32'h00100004.
  - With `DMEM_ARB_RR_EN`, grants go 0,1,0,1.
  - Without it, grants go 0,0,0,0 while p0 stays valid.
- Misaligned: p0 word write to 32'h00100002.
  - Expect resp_valid at T+1 with err=1 and `mem_en`=2'b00 throughout.
  - A halfword we=4'b1100 to 32'h00100002 expects err=0.
- Reset in WAIT: with MEM_LAT=3, assert rst during the second WAIT cycle.
  - Expect all outputs at reset values within the same cycle and no resp_valid afterwards.
  - A subsequent read of 32'h00100008 completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port valid/ready arbiter and one-at-a-time access sequencer for dmem
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    input  logic          p1_valid,
    output logic          p0_ready,
    output logic          p1_ready,
    input  logic [3:0]    p0_we,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [31:0]   p1_wdata,
    output logic          p0_resp_valid,
    output logic          p1_resp_valid,
    output logic          p0_resp_err,
    output logic          p1_resp_err,
    output logic [31:0]   p0_rdata,
    output logic [31:0]   p1_rdata,
    output logic [1:0]    mem_en,
    output logic [3:0]    mem_w_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [3:0]    we_q, we_d;
    logic          err_q, err_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [31:0]   mdin_q, mdin_d;

    logic          win;
    logic          accept;
    logic [3:0]    win_we;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic          win_err;

`ifdef DMEM_ARB_RR_EN
    // ptr_q remembers the last granted port; the other one wins a tie.
    logic ptr_q;
    assign win = (p0_valid && p1_valid) ? ~ptr_q : p1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (accept) begin
            ptr_q <= win;
        end
    end
`else
    assign win = ~p0_valid;
`endif

    assign accept    = (state_q == S_IDLE) && (p0_valid || p1_valid) && !rst;
    assign win_we    = win ? p1_we    : p0_we;
    assign win_addr  = win ? p1_addr  : p0_addr;
    assign win_wdata = win ? p1_wdata : p0_wdata;

    always_comb begin
        win_err = 1'b0;
        case (win_we)
            4'b0000, 4'b1111: win_err = (win_addr[1:0] != 2'b00);
            4'b0011, 4'b1100: win_err = win_addr[0];
            default:          win_err = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        maddr_d  = maddr_q;
        mdin_d   = mdin_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gnt_d = win;
                    we_d  = win_we;
                    err_d = win_err;
                    if (win_err) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                        maddr_d = {win_addr[AW-1:2], 2'b00};
                        mdin_d  = win_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q != 4'b0000) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(MEM_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (gnt_q) rdata1_d = mem_dout;
                    else       rdata0_d = mem_dout;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 4'b0000;
            err_q    <= 1'b0;
            cnt_q    <= 3'd0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            maddr_q  <= '0;
            mdin_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            maddr_q  <= maddr_d;
            mdin_q   <= mdin_d;
        end
    end

    // Address/data registers are loaded at accept so they hold after ISSUE.
    assign mem_en        = (state_q != S_ISSUE) ? 2'b00 : ((we_q != 4'b0000) ? 2'b10 : 2'b01);
    assign mem_w_en      = (state_q == S_ISSUE) ? we_q : 4'b0000;
    assign mem_addr      = maddr_q;
    assign mem_din       = mdin_q;
    assign p0_ready      = accept && !win;
    assign p1_ready      = accept && win;
    assign p0_resp_valid = (state_q == S_RESP) && !gnt_q;
    assign p1_resp_valid = (state_q == S_RESP) && gnt_q;
    assign p0_resp_err   = p0_resp_valid && err_q;
    assign p1_resp_err   = p1_resp_valid && err_q;
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a latency-exact dmem model
module tb_dmem_arbiter;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 0, p1_valid = 0;
    logic        p0_ready, p1_ready;
    logic [3:0]  p0_we = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic        p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [1:0]  mem_en;
    logic [3:0]  mem_w_en;
    logic [31:0] mem_addr, mem_din, mem_dout;

    dmem_arbiter #(.MEM_LAT(LAT), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
        .p0_we(p0_we), .p1_we(p1_we), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_resp_valid(p0_resp_valid), .p1_resp_valid(p1_resp_valid),
        .p0_resp_err(p0_resp_err), .p1_resp_err(p1_resp_err),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A5A5A;
    endfunction

    // Bus-level dmem: read data is valid only in the cycle exactly LAT after the issue cycle.
    logic [31:0] dmem [int];
    int          rd_cyc = -100;
    logic [31:0] rd_val = 0;
    assign mem_dout = (cyc == rd_cyc) ? rd_val : 32'hBAD0BAD0;

    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en == 2'b01) begin
            rd_cyc <= cyc + LAT;
            rd_val <= dmem.exists(int'(mem_addr >> 2)) ? dmem[int'(mem_addr >> 2)] : init_word(mem_addr >> 2);
        end
        if (mem_en == 2'b10) begin
            w = dmem.exists(int'(mem_addr >> 2)) ? dmem[int'(mem_addr >> 2)] : init_word(mem_addr >> 2);
            for (int b = 0; b < 4; b++) if (mem_w_en[b]) w[8*b +: 8] = mem_din[8*b +: 8];
            dmem[int'(mem_addr >> 2)] = w;
        end
    end

    int          en_cnt = 0;
    int          rv_cnt [2];
    logic [1:0]  mon_en;
    logic [3:0]  mon_wen;
    logic [31:0] mon_addr, mon_din;
    initial begin rv_cnt[0] = 0; rv_cnt[1] = 0; end
    always @(negedge clk) begin
        if (mem_en != 2'b00) begin
            en_cnt++; mon_en = mem_en; mon_wen = mem_w_en; mon_addr = mem_addr; mon_din = mem_din;
        end
        if (p0_resp_valid) rv_cnt[0]++;
        if (p1_resp_valid) rv_cnt[1]++;
    end

    // Transaction-level reference: word memory plus per-port expected rdata.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata [2];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : init_word(a >> 2);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] w = ref_read(a);
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a >> 2)] = w;
    endfunction

    function automatic bit ref_err(input logic [3:0] we, input logic [31:0] a);
        if (we == 4'b0000 || we == 4'b1111) return a % 4 != 0;
        if (we == 4'b0011 || we == 4'b1100) return a % 2 != 0;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 0);
        check({tag, "_mem_w_en"}, 32'(mem_w_en), 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_din"}, mem_din, 0);
        check({tag, "_rdata"}, {p0_rdata ^ p1_rdata}, 0);
        check({tag, "_rdata0"}, p0_rdata, 0);
        check({tag, "_resp"}, {28'h0, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err}, 0);
        check({tag, "_ready"}, {30'h0, p0_ready, p1_ready}, 0);
    endtask

    task automatic txn(input int port, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input int exp_lat, input string tag);
        int acc = 0, n = 0, lat = 0;
        bit got = 0;
        logic err = 0;
        logic [31:0] rd_now = 0;
        en_cnt = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
        if (port == 0) begin p0_valid = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
        else           begin p1_valid = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        while (!got && n < 10) begin
            @(negedge clk);
            if ((port == 0) ? p0_ready : p1_ready) begin got = 1; acc = cyc; end
            @(posedge clk); #1; n++;
        end
        p0_valid = 0; p1_valid = 0;
        check({tag, "_accept"}, 32'(got), 1);
        if (!got) return;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if ((port == 0) ? p0_resp_valid : p1_resp_valid) begin
                got = 1; lat = cyc - acc;
                err = (port == 0) ? p0_resp_err : p1_resp_err;
                rd_now = (port == 0) ? p0_rdata : p1_rdata;
            end
            n++;
        end
        @(posedge clk); #1; @(negedge clk); @(posedge clk); #1;
        check({tag, "_resp"}, 32'(got), 1);
        if (!exp_err) begin
            if (we != 4'b0000) ref_write(addr, we, wd);
            else exp_rdata[port] = ref_read(addr);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rd_now, exp_rdata[port]);
        check({tag, "_other_rdata"}, (port == 0) ? p1_rdata : p0_rdata, exp_rdata[1 - port]);
        check({tag, "_resp_cnt"}, rv_cnt[port], 1);
        check({tag, "_other_resp"}, rv_cnt[1 - port], 0);
        check({tag, "_en_cnt"}, en_cnt, exp_err ? 0 : 1);
        if (!exp_err) begin
            check({tag, "_bus"}, {mon_en, mon_wen, 26'h0}, {(we != 0) ? 2'b10 : 2'b01, we, 26'h0});
            check({tag, "_bus_addr"}, mon_addr, {addr[31:2], 2'b00});
            if (we != 0) check({tag, "_bus_din"}, mon_din, wd);
        end
    endtask

    typedef struct {
        int          port;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        logic [3:0]  we_tab [6];
        int          exp_gnt [4];
        int          k, n, prev, gp, rvs;
        logic [3:0]  we;
        logic [31:0] a;
        bit          e;

        exp_rdata[0] = 0; exp_rdata[1] = 0;
        we_tab = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0100};
        tbl[0] = '{0, 4'b1111, 32'h00100000, 32'h20221118, 1'b0, 2};
        tbl[1] = '{1, 4'b0000, 32'h00100000, 32'h0,        1'b0, 2 + LAT};
        tbl[2] = '{0, 4'b1111, 32'h00100002, 32'h11223344, 1'b1, 1};
        tbl[3] = '{0, 4'b1100, 32'h00100002, 32'hABCD0000, 1'b0, 2};
        tbl[4] = '{0, 4'b0000, 32'h00100002, 32'h0,        1'b1, 1};
        tbl[5] = '{1, 4'b0011, 32'h00100001, 32'h00005566, 1'b1, 1};
        tbl[6] = '{1, 4'b0001, 32'h00100003, 32'h000000EE, 1'b0, 2};
        tbl[7] = '{0, 4'b0000, 32'h00100000, 32'h0,        1'b0, 2 + LAT};

        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 8; i++)
            txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_lat,
                $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            we = we_tab[$urandom_range(0, 5)];
            a  = 32'h00100000 + 32'($urandom_range(0, 31));
            e  = ref_err(we, a);
            txn(int'($urandom_range(0, 1)), we, a, $urandom, e, e ? 1 : ((we != 0) ? 2 : 2 + LAT),
                $sformatf("rnd%0d", i));
        end

        // Reset during the second WAIT cycle of a read.
        p0_valid = 1; p0_we = 0; p0_addr = 32'h00100000;
        @(negedge clk); check("rstw_accept", 32'(p0_ready), 1);
        @(posedge clk); #1 p0_valid = 0;
        @(negedge clk); check("rstw_issue", 32'(mem_en), 32'(2'b01));
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1; p1_valid = 1; p1_we = 0; p1_addr = 32'h00100008;
        #1 check_reset("rstw");
        @(posedge clk); #1 rst = 0; p1_valid = 0;
        exp_rdata[0] = 0; exp_rdata[1] = 0;
        rvs = 0;
        repeat (8) begin @(negedge clk); rvs += p0_resp_valid + p1_resp_valid; end
        check("rstw_no_resp", rvs, 0);
        @(posedge clk); #1;

        // Contention: both ports hold word writes to the same address.
`ifdef DMEM_ARB_RR_EN
        exp_gnt = '{0, 1, 0, 1};
`else
        exp_gnt = '{0, 0, 0, 0};
`endif
        rv_cnt[0] = 0; rv_cnt[1] = 0;
        p0_valid = 1; p0_we = 4'b1111; p0_addr = 32'h00100004; p0_wdata = 32'h11110000;
        p1_valid = 1; p1_we = 4'b1111; p1_addr = 32'h00100004; p1_wdata = 32'h22220000;
        k = 0; n = 0; prev = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                gp = p1_ready ? 1 : 0;
                check($sformatf("cont_gnt%0d", k), gp, exp_gnt[k]);
                check($sformatf("cont_onehot%0d", k), 32'(p0_ready && p1_ready), 0);
                if (k > 0) check($sformatf("cont_gap%0d", k), cyc - prev, 3);
                prev = cyc; k++;
            end
            @(posedge clk); #1; n++;
        end
        p0_valid = 0; p1_valid = 0;
        check("cont_accepts", k, 4);
        repeat (4) @(posedge clk); #1;
        check("cont_p0_resps", rv_cnt[0], (exp_gnt[1] == 1) ? 2 : 4);
        check("cont_p1_resps", rv_cnt[1], (exp_gnt[1] == 1) ? 2 : 0);
        ref_write(32'h00100004, 4'b1111, (exp_gnt[3] == 1) ? 32'h22220000 : 32'h11110000);

        txn(1, 4'b0000, 32'h00100004, 32'h0, 1'b0, 2 + LAT, "cont_rd");
        txn(0, 4'b0000, 32'h00100008, 32'h0, 1'b0, 2 + LAT, "post_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected %0d checks to complete", n_checks);
        $fatal(1);
    end
endmodule
